mux_scan_n: RTL and testbench

Parametrised, registered N:1 multiplexer with a built-in channel sequencer, the next generation of the three-level 8:1 select-line mux in the Mux_Counters_Flip_Flops lab set. It selects one WIDTH-bit channel out of CHANNELS, either from an external select (manual mode) or from an internal scan counter that dwells DWELL cycles per channel and wraps (auto mode). The output, channel tag, wrap pulse and error flag are registered, so the block can feed counters, displays or serial shifters directly.

---
 rtl/mux_scan_n.sv | 91 +++++++++
 tb/tb_mux_scan_n.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// Registered N:1 channel mux with a built-in scan sequencer.
// Manual mode follows sel_in; auto mode steps through the channels and stays
// DWELL cycles on each one. out/out_ch always reflect the channel held before
// the current edge, so data latency is 1 cycle and select latency is 2.
module mux_scan_n #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 1,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      run,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    output logic                      wrap,
    output logic                      sel_err
);

    // dwell counter needs at least one bit even when DWELL == 1
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [DW-1:0]    LAST_DW = DW'(DWELL - 1);
    // one extra bit so CHANNELS itself is representable for the range test
    localparam logic [SEL_W:0]   NUM_CH  = (SEL_W + 1)'(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] chan;
    logic [SEL_W-1:0]               ch, ch_nxt;
    logic [DW-1:0]                  dwell_cnt, dwell_nxt;
    logic                           wrap_nxt, err_nxt;
    logic                           sel_ok;

    assign chan   = in_bus;
    assign sel_ok = ({1'b0, sel_in} < NUM_CH);

    // Next channel / dwell selection; mode is checked first so a manual
    // request always overrides a pending terminal count (no stray wrap).
    always_comb begin
        ch_nxt    = ch;
        dwell_nxt = dwell_cnt;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (!mode) begin
            dwell_nxt = '0;
            if (sel_ok) begin
                ch_nxt = sel_in;
            end else begin
                ch_nxt  = '0;
                err_nxt = 1'b1;
            end
        end else if (run) begin
            if (dwell_cnt == LAST_DW) begin
                dwell_nxt = '0;
                if (ch == LAST_CH) begin
                    ch_nxt   = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    ch_nxt = ch + 1'b1;
                end
            end else begin
                dwell_nxt = dwell_cnt + 1'b1;
            end
        end
    end

    // Sequencer state plus output registers; outputs sample the pre-update ch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch        <= '0;
            dwell_cnt <= '0;
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            ch        <= ch_nxt;
            dwell_cnt <= dwell_nxt;
            out       <= chan[ch];
            out_ch    <= ch;
            out_valid <= 1'b1;
            wrap      <= wrap_nxt;
            sel_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: three instances cover the default 8:1 mux,
// a 5-channel DWELL=3 scanner and an 8-channel DWELL=3 scanner.
module tb_mux_scan_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // instance A: WIDTH=4, CHANNELS=8, DWELL=1
    logic [31:0] in_a;
    logic        mode_a, run_a;
    logic [2:0]  sel_a;
    logic [3:0]  out_a;
    logic [2:0]  och_a;
    logic        vld_a, wrap_a, err_a;

    // instance B: WIDTH=4, CHANNELS=5, DWELL=3
    logic [19:0] in_b;
    logic        mode_b, run_b;
    logic [2:0]  sel_b;
    logic [3:0]  out_b;
    logic [2:0]  och_b;
    logic        vld_b, wrap_b, err_b;

    // instance C: WIDTH=4, CHANNELS=8, DWELL=3
    logic [31:0] in_c;
    logic        mode_c, run_c;
    logic [2:0]  sel_c;
    logic [3:0]  out_c;
    logic [2:0]  och_c;
    logic        vld_c, wrap_c, err_c;

    mux_scan_n #(.WIDTH(4), .CHANNELS(8), .DWELL(1)) dut_a (
        .clk(clk), .rst(rst), .in_bus(in_a), .mode(mode_a), .sel_in(sel_a),
        .run(run_a), .out(out_a), .out_ch(och_a), .out_valid(vld_a),
        .wrap(wrap_a), .sel_err(err_a));

    mux_scan_n #(.WIDTH(4), .CHANNELS(5), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .in_bus(in_b), .mode(mode_b), .sel_in(sel_b),
        .run(run_b), .out(out_b), .out_ch(och_b), .out_valid(vld_b),
        .wrap(wrap_b), .sel_err(err_b));

    mux_scan_n #(.WIDTH(4), .CHANNELS(8), .DWELL(3)) dut_c (
        .clk(clk), .rst(rst), .in_bus(in_c), .mode(mode_c), .sel_in(sel_c),
        .run(run_c), .out(out_c), .out_ch(och_c), .out_valid(vld_c),
        .wrap(wrap_c), .sel_err(err_c));

    typedef struct {
        bit         on_b;
        logic [2:0] sel;
        logic [3:0] exp_out;
        logic [2:0] exp_ch;
        logic       exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Free-running scan of B from reset: edge n shows channel ((n-1)/3)%5,
    // wrap fires on every 15th edge; sel_in is parked out of range throughout.
    task automatic auto_b(input int edges);
        for (int n = 1; n <= edges; n++) begin
            int exp_ch;
            tick();
            exp_ch = ((n - 1) / 3) % 5;
            chk($sformatf("b_scan_ch[%0d]", n), 32'(och_b), 32'(exp_ch));
            chk($sformatf("b_scan_out[%0d]", n), 32'(out_b), 32'(exp_ch + 1));
            chk($sformatf("b_scan_wrap[%0d]", n), 32'(wrap_b), 32'((n % 15) == 0));
            chk($sformatf("b_scan_err[%0d]", n), 32'(err_b), 32'(0));
        end
    endtask

    initial begin
        in_a = 32'h8765_432A; mode_a = 1'b0; sel_a = 3'd0; run_a = 1'b0;
        in_b = 20'h54321;     mode_b = 1'b0; sel_b = 3'd0; run_b = 1'b0;
        in_c = 32'h8765_4321; mode_c = 1'b1; sel_c = 3'd0; run_c = 1'b1;

        // manual sweep on A, then out-of-range handling on B
        for (int k = 0; k < 8; k++)
            vecs[k] = '{1'b0, 3'(k), 4'(k + 1), 3'(k), 1'b0};
        vecs[8]  = '{1'b1, 3'd6, 4'h1, 3'd0, 1'b1};
        vecs[9]  = '{1'b1, 3'd3, 4'h4, 3'd3, 1'b0};
        vecs[10] = '{1'b1, 3'd5, 4'h1, 3'd0, 1'b1};
        vecs[11] = '{1'b1, 3'd4, 4'h5, 3'd4, 1'b0};

        // reset state
        #3;
        chk("rst_out", 32'(out_a), 32'h0);
        chk("rst_valid", 32'(vld_a), 32'h0);
        chk("rst_ch", 32'(och_a), 32'h0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("first_out", 32'(out_a), 32'hA);
        chk("first_ch", 32'(och_a), 32'h0);
        chk("first_valid", 32'(vld_a), 32'h1);

        // asynchronous reset mid-cycle clears outputs at once
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(out_a), 32'h0);
        chk("async_rst_valid", 32'(vld_a), 32'h0);
        @(negedge clk) rst = 1'b0;
        in_a = 32'h8765_4321;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].on_b) sel_b = vecs[i].sel;
            else              sel_a = vecs[i].sel;
            tick();
            tick();
            if (vecs[i].on_b) begin
                chk($sformatf("vec%0d_out", i), 32'(out_b), 32'(vecs[i].exp_out));
                chk($sformatf("vec%0d_ch", i), 32'(och_b), 32'(vecs[i].exp_ch));
                chk($sformatf("vec%0d_err", i), 32'(err_b), 32'(vecs[i].exp_err));
            end else begin
                chk($sformatf("vec%0d_out", i), 32'(out_a), 32'(vecs[i].exp_out));
                chk($sformatf("vec%0d_ch", i), 32'(och_a), 32'(vecs[i].exp_ch));
                chk($sformatf("vec%0d_err", i), 32'(err_a), 32'(vecs[i].exp_err));
            end
        end
        chk("valid_held", 32'(vld_a), 32'h1);

        // auto scan on B from reset, 40 edges leaves ch=3, dwell_cnt=1
        @(negedge clk) rst = 1'b1;
        mode_b = 1'b1; run_b = 1'b1; sel_b = 3'd6;
        @(negedge clk) rst = 1'b0;
        auto_b(40);
        #2 rst = 1'b1;
        #1;
        chk("midscan_rst_ch", 32'(och_b), 32'h0);
        chk("midscan_rst_out", 32'(out_b), 32'h0);
        chk("midscan_rst_valid", 32'(vld_b), 32'h0);
        @(negedge clk) rst = 1'b0;
        auto_b(4);

        // freeze on C: reach ch=2 dwell_cnt=1 after 7 edges
        @(negedge clk) rst = 1'b1;
        mode_c = 1'b1; run_c = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            tick();
            chk($sformatf("c_scan_ch[%0d]", n), 32'(och_c), 32'(((n - 1) / 3) % 8));
        end
        run_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) in_c[11:8] = 4'hF;
            tick();
            chk($sformatf("freeze_ch[%0d]", i), 32'(och_c), 32'h2);
            chk($sformatf("freeze_out[%0d]", i), 32'(out_c), (i >= 2) ? 32'hF : 32'h3);
        end
        run_c = 1'b1;
        tick(); chk("resume_ch0", 32'(och_c), 32'h2);
        tick(); chk("resume_ch1", 32'(och_c), 32'h2);
        tick(); chk("resume_ch2", 32'(och_c), 32'h3);

        // walk to ch=7 at terminal dwell, then switch to manual on that edge
        repeat (13) tick();
        chk("pre_switch_ch", 32'(och_c), 32'h7);
        mode_c = 1'b0; sel_c = 3'd6;
        tick();
        chk("switch_wrap0", 32'(wrap_c), 32'h0);
        chk("switch_err0", 32'(err_c), 32'h0);
        chk("switch_ch0", 32'(och_c), 32'h7);
        tick();
        chk("switch_wrap1", 32'(wrap_c), 32'h0);
        chk("switch_ch1", 32'(och_c), 32'h6);
        chk("switch_out1", 32'(out_c), 32'h7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
